hbridge_gate_drv: RTL

//  Downstream of the PWM stage. Converts PWM/DIR/OFF into four H-bridge gate drives (legs A, B)

---
 rtl/hbridge_gate_drv.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hbridge_gate_drv.sv
`timescale 1ns/1ps
// H-bridge gate driver: turns PWM/DIR/OFF into four gate drives with dead time,
// a direction-reversal gap, overcurrent trip/hold/retry and a latched fault.
//  state  | meaning
//  IDLE   | gates off, waiting out the start-up gap
//  RUN    | legs driven from PWM_in and the latched direction
//  DIRCHG | gates off while a direction change settles
//  TRIP   | gates off until OFF has been low for the hold time
//  LOCK   | gates off, Fault high until cleared
module hbridge_gate_drv #(
    parameter int unsigned DEAD_CYC     = 60,
    parameter int unsigned DIR_GAP_CYC  = 120,
    parameter int unsigned OFF_HOLD_CYC = 3000,
    parameter int unsigned TRIP_WIN     = 60000,
    parameter int unsigned FAULT_LIMIT  = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       RESET,
    input  logic       PWM_in,
    input  logic       DIR,
    input  logic       OFF,
    input  logic       Fault_clr,
    output logic       HA_hi,
    output logic       HA_lo,
    output logic       HB_hi,
    output logic       HB_lo,
    output logic       Fault,
    output logic [2:0] State
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DIRCHG = 3'd2,
        S_TRIP   = 3'd3,
        S_LOCK   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DIR_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(OFF_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(TRIP_WIN - 1);
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(FAULT_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d, hold_q, hold_d, win_q, win_d;
    logic [CNT_W-1:0] trip_q, trip_d, trip_inc;
    logic             dir_q, dir_d, dir_smp_q;
    logic             trip_ev, run_stay;
    logic [3:0]       req_q, req_d, req_cur, gate_q, gate_d;
    logic [CNT_W-1:0] dcnt_q [4];
    logic [CNT_W-1:0] dcnt_d [4];
    logic             fault_q, fault_d;

    // Gate order {A_hi, A_lo, B_hi, B_lo}; dir=1 mirrors the legs.
    function automatic logic [3:0] leg_req(input logic pwm, input logic d);
        return d ? {1'b0, 1'b1, pwm, ~pwm} : {pwm, ~pwm, 1'b0, 1'b1};
    endfunction

    always_ff @(posedge i_clk or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            hold_q    <= '0;
            win_q     <= '0;
            trip_q    <= '0;
            dir_q     <= 1'b0;
            dir_smp_q <= 1'b0;
            req_q     <= '0;
            gate_q    <= '0;
            fault_q   <= 1'b0;
            for (int g = 0; g < 4; g++) dcnt_q[g] <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            hold_q    <= hold_d;
            win_q     <= win_d;
            trip_q    <= trip_d;
            dir_q     <= dir_d;
            dir_smp_q <= DIR;
            req_q     <= req_d;
            gate_q    <= gate_d;
            fault_q   <= fault_d;
            for (int g = 0; g < 4; g++) dcnt_q[g] <= dcnt_d[g];
        end
    end

    assign trip_inc = (trip_q == '1) ? trip_q : trip_q + ONE;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        win_d   = '0;
        trip_d  = trip_q;
        dir_d   = dir_q;
        trip_ev = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (OFF) trip_ev = 1'b1;
                else if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    dir_d   = DIR;
                end else gap_d = gap_q + ONE;
            end
            S_RUN: begin
                if (OFF) trip_ev = 1'b1;
                else begin
                    if (win_q == WIN_LAST) trip_d = '0;
                    else win_d = win_q + ONE;
                    if (DIR != dir_q) begin
                        state_d = S_DIRCHG;
                        gap_d   = '0;
                    end
                end
            end
            S_DIRCHG: begin
                if (OFF) trip_ev = 1'b1;
                else if (DIR != dir_smp_q) gap_d = '0;
                else if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    dir_d   = DIR;
                end else gap_d = gap_q + ONE;
            end
            S_TRIP: begin
                if (OFF) hold_d = '0;
                else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    dir_d   = DIR;
                end else hold_d = hold_q + ONE;
            end
            S_LOCK: begin
                if (Fault_clr && !OFF) begin
                    state_d = S_IDLE;
                    trip_d  = '0;
                    gap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (trip_ev) begin
            trip_d  = trip_inc;
            hold_d  = '0;
            state_d = (trip_inc == LIMIT_C) ? S_LOCK : S_TRIP;
        end
    end

    // A gate may only rise after its request has been stable for DEAD_CYC RUN cycles.
    always_comb begin
        run_stay = (state_q == S_RUN) && (state_d == S_RUN);
        req_cur  = leg_req(PWM_in, dir_q);
        req_d    = leg_req(PWM_in, dir_d);
        fault_d  = (state_d == S_LOCK);
        gate_d   = '0;
        for (int g = 0; g < 4; g++) begin
            dcnt_d[g] = '0;
            if (run_stay && (req_cur[g] == req_q[g]))
                dcnt_d[g] = (dcnt_q[g] >= DEAD_C) ? dcnt_q[g] : dcnt_q[g] + ONE;
            gate_d[g] = run_stay && req_cur[g] && (dcnt_d[g] >= DEAD_C);
        end
    end

    assign {HA_hi, HA_lo, HB_hi, HB_lo} = gate_q;
    assign Fault = fault_q;
    assign State = state_q;

endmodule
